// File: rtl/gemv_tile_sequencer_if.sv
// Read-port and control bundle of the GEMV tile sequencer.
// master drives commands and consume returns; slave is the sequencer.
interface gemv_tile_sequencer_if #(
  parameter int DIM_W = 16
);
  logic               start;
  logic               abort;
  logic [DIM_W-1:0]   num_rows;
  logic [DIM_W-1:0]   num_cols;
  logic [4:0]         vec_buf_id;
  logic [4:0]         mat_buf_id;
  logic               tile_consume;
  logic               rd_en;
  logic [4:0]         vec_read_buffer_id;
  logic [4:0]         mat_read_buffer_id;
  logic [DIM_W-1:0]   vec_tile_idx;
  logic [2*DIM_W-1:0] mat_tile_idx;
  logic               out_valid;
  logic [DIM_W-1:0]   out_row_idx;
  logic               out_row_last;
  logic               out_last;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, num_rows, num_cols,
    output vec_buf_id, mat_buf_id, tile_consume,
    input  rd_en, vec_read_buffer_id, mat_read_buffer_id,
    input  vec_tile_idx, mat_tile_idx, out_valid,
    input  out_row_idx, out_row_last, out_last,
    input  busy, done
  );

  modport slave (
    input  start, abort, num_rows, num_cols,
    input  vec_buf_id, mat_buf_id, tile_consume,
    output rd_en, vec_read_buffer_id, mat_read_buffer_id,
    output vec_tile_idx, mat_tile_idx, out_valid,
    output out_row_idx, out_row_last, out_last,
    output busy, done
  );
endinterface

// File: rtl/gemv_tile_sequencer.sv
// Issues paired vector/matrix tile reads for one GEMV pass,
// credit-throttled, with row/last tags aligned to read latency.
module gemv_tile_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int TILE_ELEMS   = 32,
  parameter int READ_LATENCY = 2,
  parameter int CREDITS      = 4,
  parameter int DIM_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  gemv_tile_sequencer_if.slave sif
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int MW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] TILE_N = DIM_W'(TILE_ELEMS);
  localparam logic [CW-1:0] CRED_N = CW'(CREDITS);

  if (DATA_WIDTH < 1 || TILE_ELEMS < 1 ||
      READ_LATENCY < 1 || CREDITS < 1) begin : g_bad_param
    $error("gemv_tile_sequencer: bad parameter");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic             v;
    logic [DIM_W-1:0] row;
    logic             row_last;
    logic             last;
  } tag_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIM_W-1:0] r_tpr;
  logic [MW-1:0]    r_total;
  logic [DIM_W-1:0] r_nxt_col;
  logic [DIM_W-1:0] r_nxt_row;
  logic [MW-1:0]    r_nxt_mat;
  logic [CW-1:0]    r_cnt;
  logic             r_rd_en;
  logic [DIM_W-1:0] r_vec_idx;
  logic [MW-1:0]    r_mat_idx;
  logic [DIM_W-1:0] r_row;
  logic             r_row_last;
  logic             r_last;
  logic [4:0]       r_vec_id;
  logic [4:0]       r_mat_id;
  logic             r_busy;
  logic             r_done;
  tag_t             r_pipe [READ_LATENCY];

  logic             w_dims_ok;
  logic             w_start_idle;
  logic             w_start_ok;
  logic             w_start_nil;
  logic             w_consume;
  logic [CW-1:0]    w_cnt_nxt;
  logic [DIM_W-1:0] w_tpr_in;
  logic [MW-1:0]    w_total_in;
  logic [DIM_W-1:0] w_tpr;
  logic [MW-1:0]    w_total;
  logic [DIM_W-1:0] w_col;
  logic [DIM_W-1:0] w_row;
  logic [MW-1:0]    w_mat;
  logic             w_row_last;
  logic             w_last;
  logic             w_issue;
  logic             w_done;
  logic             w_pipe_idle;

  assign w_tpr_in = sif.num_cols / TILE_N
                  + DIM_W'(sif.num_cols % TILE_N != '0);
  assign w_total_in = MW'(sif.num_rows) * MW'(w_tpr_in);

  assign w_dims_ok    = |sif.num_rows && |sif.num_cols;
  assign w_start_idle = r_state == S_IDLE && sif.start
                      && !sif.abort;
  assign w_start_ok   = w_start_idle && w_dims_ok;
  assign w_start_nil  = w_start_idle && !w_dims_ok;

  // A consume with nothing outstanding is dropped
  assign w_consume = sif.tile_consume && r_cnt != '0;
  assign w_cnt_nxt = r_cnt + CW'(r_rd_en) - CW'(w_consume);

  // The first issue of a pass uses the freshly sampled sizes
  assign w_tpr   = w_start_ok ? w_tpr_in   : r_tpr;
  assign w_total = w_start_ok ? w_total_in : r_total;
  assign w_col   = w_start_ok ? '0 : r_nxt_col;
  assign w_row   = w_start_ok ? '0 : r_nxt_row;
  assign w_mat   = w_start_ok ? '0 : r_nxt_mat;

  assign w_row_last = w_col == w_tpr - DIM_W'(1);
  assign w_last     = w_mat == w_total - MW'(1);

  always_comb begin
    w_pipe_idle = !r_rd_en;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      if (r_pipe[i].v) w_pipe_idle = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = w_start_nil;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_ISSUE;
          w_issue     = w_cnt_nxt < CRED_N;
        end
      end
      S_ISSUE: begin
        w_issue = r_nxt_mat != r_total
                && w_cnt_nxt < CRED_N;
        if (r_rd_en && r_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cnt_nxt == '0 && w_pipe_idle) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (sif.abort) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tpr      <= '0;
      r_total    <= '0;
      r_nxt_col  <= '0;
      r_nxt_row  <= '0;
      r_nxt_mat  <= '0;
      r_cnt      <= '0;
      r_rd_en    <= 1'b0;
      r_vec_idx  <= '0;
      r_mat_idx  <= '0;
      r_row      <= '0;
      r_row_last <= 1'b0;
      r_last     <= 1'b0;
      r_vec_id   <= '0;
      r_mat_id   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_en <= w_issue;
      r_busy  <= w_state_nxt != S_IDLE;
      r_done  <= w_done;
      r_cnt   <= sif.abort ? '0 : w_cnt_nxt;
      if (w_start_idle) begin
        r_vec_id <= sif.vec_buf_id;
        r_mat_id <= sif.mat_buf_id;
      end
      if (w_start_ok) begin
        r_tpr   <= w_tpr_in;
        r_total <= w_total_in;
      end
      if (w_issue) begin
        r_vec_idx  <= w_col;
        r_mat_idx  <= w_mat;
        r_row      <= w_row;
        r_row_last <= w_row_last;
        r_last     <= w_last;
        r_nxt_col  <= w_row_last ? '0 : w_col + DIM_W'(1);
        r_nxt_row  <= w_row + DIM_W'(w_row_last);
        r_nxt_mat  <= w_mat + MW'(1);
      end
    end
  end

  // Tags ride alongside the buffer read so they surface with the data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
    end else if (sif.abort) begin
      for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= r_rd_en
                 ? {1'b1, r_row, r_row_last, r_last}
                 : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign sif.rd_en              = r_rd_en;
  assign sif.vec_read_buffer_id = r_vec_id;
  assign sif.mat_read_buffer_id = r_mat_id;
  assign sif.vec_tile_idx       = r_vec_idx;
  assign sif.mat_tile_idx       = r_mat_idx;
  assign sif.out_valid          = r_pipe[READ_LATENCY-1].v;
  assign sif.out_row_idx        = r_pipe[READ_LATENCY-1].row;
  assign sif.out_row_last       = r_pipe[READ_LATENCY-1].row_last;
  assign sif.out_last           = r_pipe[READ_LATENCY-1].last;
  assign sif.busy               = r_busy;
  assign sif.done               = r_done;
endmodule

// File: doc/gemv_tile_sequencer.md
# gemv_tile_sequencer

Sequences tile reads from the vector and matrix buffers for one matrix-vector (GEMV) pass, and drives the read ports of the buffer controller.
- For every output row it walks all column tiles, issuing one paired vector and matrix tile read per tile slot.
- It tags each returning tile with row/last markers aligned to the buffer read latency.
- It throttles issue with a credit counter so the downstream MAC array is never overrun.

## Interface
Parameters:
- DATA_WIDTH, 8, element width in bits
- TILE_ELEMS, 32, elements per tile
- READ_LATENCY, 2, cycles from read-enable to buffer data valid (≥1)
- CREDITS, 4, maximum tiles issued but not yet consumed (≥1)
- DIM_W, 16, width of row/column counts

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a pass (ignored unless IDLE)
- abort  in  1  one-cycle pulse, cancels the pass
- num_rows  in  DIM_W  output rows, sampled at start
- num_cols  in  DIM_W  input length in elements, sampled at start
- vec_buf_id  in  5  vector buffer ID, sampled at start
- mat_buf_id  in  5  matrix buffer ID, sampled at start
- rd_en  out  1  paired read strobe (drives vec and mat read enables)
- vec_read_buffer_id  out  5  registered copy of vec_buf_id
- mat_read_buffer_id  out  5  registered copy of mat_buf_id
- vec_tile_idx  out  DIM_W  column-tile index of the current issue
- mat_tile_idx  out  2*DIM_W  linear matrix tile index of the current issue
- out_valid  out  1  tile data at buffer outputs is valid this cycle
- out_row_idx  out  DIM_W  row of the tile on out_valid
- out_row_last  out  1  tile is last of its row
- out_last  out  1  tile is last of the pass
- tile_consume  in  1  consumer has retired one tile (returns one credit)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at pass completion

## Operation
- Tiles per row: TPR = ceil(num_cols / TILE_ELEMS), computed at start in DIM_W bits. Total tiles: num_rows*TPR in 2*DIM_W bits.
- States: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on start when num_rows≠0 and num_cols≠0.
  - start with num_rows=0 or num_cols=0 → done pulses the next cycle, state stays IDLE, no reads are issued.
  - ISSUE → DRAIN the cycle after the final rd_en.
  - DRAIN → IDLE when all issued tiles are consumed (credit count 0 and tag pipe empty); done pulses in that transition cycle.
- Issue rule: rd_en=1 in ISSUE iff credit_cnt < CREDITS. Each issue advances the indices:
  - vec_tile_idx increments and wraps to 0 after TPR-1; the row counter increments on that wrap.
  - mat_tile_idx increments linearly from 0.
- credit_cnt: +1 on rd_en, −1 on tile_consume; both in the same cycle → unchanged. tile_consume at credit_cnt=0 is ignored.
- Tag pipe: a READ_LATENCY-deep shift register carries {valid, row_idx, row_last, last} from the issue cycle, so out_* coincide with buffer data.
- abort (any state): next cycle the block is IDLE, the tag pipe is cleared, credit_cnt=0, and no done pulse is generated. abort takes priority over start in the same cycle.
- start while busy is ignored; sampled parameters are held until the next accepted start.

## Timing
- Reset values: rd_en=0, out_valid=0, out_row_last=0, out_last=0, busy=0, done=0, all indices/IDs/out_row_idx=0, credit_cnt=0, state IDLE.
- start accepted at cycle T → busy=1 and first rd_en at T+1 (vec_tile_idx=0, mat_tile_idx=0).
- rd_en at cycle N → matching out_valid at N+READ_LATENCY.
- With tile_consume returned on every out_valid cycle and CREDITS > READ_LATENCY, issue is back-to-back (one tile per cycle).
- All outputs are registered; no combinational path from tile_consume to rd_en.

## Test plan
- num_rows=2, num_cols=64, CREDITS=4, tile_consume on every out_valid:
  - 4 consecutive rd_en with vec_tile_idx 0,1,0,1 and mat_tile_idx 0..3.
  - out_row_last on tiles 1 and 3; out_last on tile 3.
  - done 1 cycle after the final consume.
- num_cols=33 → TPR=2. num_rows=1 → 2 issues, out_last on the second.
- num_rows=0 with start → done at T+1, no rd_en, busy stays 0.
- CREDITS=2, tile_consume withheld: exactly 2 rd_en, then stall. One consume pulse → exactly one further rd_en the next cycle.
- abort 3 cycles after start on a 4×4-tile pass: next cycle busy=0 and out_valid=0 thereafter, no done. A new start then restarts with indices at 0.
- reset_n asserted mid-pass: all outputs take reset values immediately (asynchronous). After release the block is IDLE and accepts start.
